// File: rtl/tilt_calib_ctrl.sv
// tilt_calib_ctrl: X-axis zero-offset calibration, offset correction and watchdog.
// Define TILT_IIR_EN to low-pass filter tilt_out with a 1/4 coefficient.
module tilt_calib_ctrl #(
  parameter int CAL_SHIFT      = 4,
  parameter int DEAD_ZONE      = 64,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_cal,
  input  logic               data_update,
  input  logic signed [15:0] data_x,
  output logic               cal_busy,
  output logic               cal_done,
  output logic signed [15:0] offset,
  output logic signed [15:0] tilt_out,
  output logic               tilt_valid,
  output logic [1:0]         dir,
  output logic               stale
);
  localparam int AW = 16 + CAL_SHIFT;
  localparam int CW = CAL_SHIFT + 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'((1 << CAL_SHIFT) - 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_TRIP = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CAL, LOAD, RUN} state_t;
  state_t state, state_n;

  logic                 upd_q;
  logic                 sample;
  logic                 active;
  logic                 timeout;
  logic                 cal_smp;
  logic                 run_smp;
  logic                 cap_v;
  logic [CW-1:0]        cnt;
  logic [WW-1:0]        wd;
  logic signed [AW-1:0] acc;
  logic signed [15:0]   cap;
  logic signed [15:0]   tnew;
  logic signed [17:0]   diff;

  function automatic logic signed [15:0] sat(
    input logic signed [17:0] v
  );
    if (v > 18'sd32767) return 16'sh7fff;
    if (v < -18'sd32768) return 16'sh8000;
    return v[15:0];
  endfunction

  function automatic logic [1:0] dir_of(
    input logic signed [15:0] v
  );
    if (int'(v) > DEAD_ZONE) return 2'b01;
    if (int'(v) < -DEAD_ZONE) return 2'b10;
    return 2'b00;
  endfunction

  assign sample  = data_update & ~upd_q;
  assign active  = (state == CAL) || (state == RUN);
  assign cal_smp = (state == CAL) && sample;
  assign run_smp = (state == RUN) && sample && !start_cal;
  assign timeout = active && !sample && (wd == WD_TRIP)
                && !((state == RUN) && start_cal);
  assign diff    = {{2{cap[15]}}, cap}
                 - {{2{offset[15]}}, offset};

`ifdef TILT_IIR_EN
  logic signed [15:0] d_sat;
  logic signed [17:0] d_ext;
  logic signed [17:0] t_ext;
  logic signed [17:0] step;
  assign d_sat = sat(diff);
  assign d_ext = {{2{d_sat[15]}}, d_sat};
  assign t_ext = {{2{tilt_out[15]}}, tilt_out};
  assign step  = (d_ext - t_ext) >>> 2;
  assign tnew  = sat(t_ext + step);
`else
  assign tnew = sat(diff);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state <= CAL;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start_cal) state_n = CAL;
      CAL: begin
        if (timeout) state_n = IDLE;
        else if (cal_smp && cnt == LAST) state_n = LOAD;
      end
      LOAD: state_n = RUN;
      RUN:  if (start_cal) state_n = CAL;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      upd_q      <= 1'b0;
      cnt        <= '0;
      wd         <= '0;
      acc        <= '0;
      cap        <= '0;
      cap_v      <= 1'b0;
      cal_busy   <= 1'b1;
      cal_done   <= 1'b0;
      offset     <= '0;
      tilt_out   <= '0;
      tilt_valid <= 1'b0;
      dir        <= 2'b00;
      stale      <= 1'b0;
    end else begin
      upd_q      <= data_update;
      tilt_valid <= 1'b0;
      cap_v      <= run_smp;
      if (run_smp) cap <= data_x;
      if (!active || sample || state_n != state) wd <= '0;
      else if (wd != WD_MAX) wd <= wd + 1'b1;
      if (cal_smp || run_smp) stale <= 1'b0;
      if (cal_smp) begin
        acc <= acc + {{CAL_SHIFT{data_x[15]}}, data_x};
        cnt <= cnt + 1'b1;
      end
      if (cap_v && state == RUN && !start_cal) begin
        tilt_out   <= tnew;
        dir        <= dir_of(tnew);
        tilt_valid <= 1'b1;
      end
      if (timeout) begin
        stale <= 1'b1;
        dir   <= 2'b00;
        if (state == CAL) begin
          acc      <= '0;
          cnt      <= '0;
          cal_busy <= 1'b0;
        end
      end
      if (start_cal && (state == IDLE || state == RUN)) begin
        cal_busy <= 1'b1;
        dir      <= 2'b00;
        acc      <= '0;
        cnt      <= '0;
      end
      if (start_cal && state == IDLE) stale <= 1'b0;
      if (state == LOAD) begin
        // upper slice of the sum is the floor-rounded mean
        offset   <= acc[CAL_SHIFT +: 16];
        cal_done <= 1'b1;
        cal_busy <= 1'b0;
        acc      <= '0;
        cnt      <= '0;
`ifdef TILT_IIR_EN
        tilt_out <= '0;
`endif
      end
    end
  end
endmodule

// File: doc/tilt_calib_ctrl.md
Name: tilt_calib_ctrl

Overview:
- Sequences the accelerometer X-axis datapath between the SPI interface and the smoothing/game-control logic.
- At power-up, or on request, it runs a zero-offset calibration by averaging 2^CAL_SHIFT samples.
- It then streams offset-corrected, saturated tilt values with a dead-zoned direction code to the game FSM.
- A watchdog flags a stalled sensor and neutralises the direction output while the sensor is stalled.

Parameters:
- CAL_SHIFT, 4: log2 of the calibration sample count (16 samples).
- DEAD_ZONE, 64: magnitude threshold. |tilt| <= DEAD_ZONE gives a centre direction.
- TIMEOUT_CYCLES, 50_000_000: clk cycles without a new sample before stale is raised. Minimum value 4.

Ports:
- clk  in  1  system clock, the single clock domain.
- reset_n  in  1  synchronous active-low reset.
- start_cal  in  1  one-cycle calibration request.
- data_update  in  1  sample-ready level/pulse from the SPI controller, already in the clk domain.
- data_x  in  16  signed raw X acceleration, valid when data_update rises.
- cal_busy  out  1  high while calibration is in progress.
- cal_done  out  1  high once a calibration has completed since reset.
- offset  out  16  signed zero offset currently applied.
- tilt_out  out  16  signed, saturated value of data_x - offset.
- tilt_valid  out  1  one-cycle pulse when tilt_out updates.
- dir  out  2  direction code: 00 centre, 01 right (tilt > DEAD_ZONE), 10 left (tilt < -DEAD_ZONE). 11 is never driven.
- stale  out  1  watchdog flag.

Behaviour:
- Reset (reset_n low at a clk edge):
  - FSM enters CAL, so calibration starts automatically after reset.
  - Outputs: cal_busy=1, cal_done=0, offset=0, tilt_out=0, tilt_valid=0, dir=00, stale=0.
  - Accumulator, sample count and watchdog counter cleared.
  - Edge-detect register cleared.
- Sample event:
  - Defined as data_update high at edge N and low at edge N-1, detected with an internal edge register.
  - A held-high data_update counts as one sample only.
  - data_x is captured at edge N.
- FSM states:
  - IDLE: only reached after a CAL timeout. Waits for start_cal, then goes to CAL.
  - CAL:
    - Each sample adds sign-extended data_x into a (16+CAL_SHIFT)-bit signed accumulator.
    - After the 2^CAL_SHIFT-th sample, go to LOAD.
    - start_cal is ignored in this state.
    - tilt_valid stays 0 and dir=00.
  - LOAD (1 cycle):
    - offset <= accumulator >>> CAL_SHIFT (arithmetic shift, floor rounding).
    - cal_done <= 1, cal_busy <= 0.
    - Accumulator and count cleared. Go to RUN.
  - RUN:
    - Each sample computes a 17-bit difference data_x - offset and clamps it to [-32768, 32767].
    - tilt_out, dir and tilt_valid=1 become visible after edge N+1. Latency is 1 cycle after capture.
    - start_cal goes to CAL, sets cal_busy=1 and keeps the old offset and cal_done until LOAD.
    - If a sample arrives in the same cycle as start_cal, the sample is discarded (not output and not accumulated).
- Watchdog:
  - Counts clk cycles in CAL and RUN and is cleared by every sample event.
  - When the count reaches TIMEOUT_CYCLES in RUN: stale <= 1 and dir <= 00; tilt_out is held.
  - The next sample clears stale and is processed normally.
  - When the count reaches TIMEOUT_CYCLES in CAL: go to IDLE and set stale <= 1. Accumulator discarded; offset and cal_done unchanged.
  - start_cal from IDLE clears stale.
  - The counter saturates; it does not wrap.
- Reset mid-operation: any state returns to the reset values above on the next edge, and any partial accumulation is lost.

Optional Feature:
- Macro: TILT_IIR_EN.
- Defined: tilt_out is a first-order low-pass of the saturated difference d: tilt_out <= tilt_out + ((d - tilt_out) >>> 2), computed in 17 bits and then saturated.
  - dir is derived from the filtered value.
  - The filter state is cleared to 0 on reset and on LOAD.
- Undefined: tilt_out = d directly, as above.
- Latency is identical with or without the macro.

Test Plan:
- Auto-calibration: reset, then 16 samples of data_x=0x0100 -> cal_busy falls, offset=0x0100, cal_done=1. Exactly 16 samples are consumed.
- Floor rounding: 8 samples of 0xFFFF then 8 of 0x0000 -> offset=0xFFFF (-1).
- Dead zone and direction:
  - offset=0x0100, data_x=0x0180 -> tilt_out=0x0080, dir=01.
  - data_x=0x0140 -> tilt_out=0x0040, dir=00.
  - data_x=0x00BF -> tilt_out=0xFFBF, dir=10.
  - Each case gives one tilt_valid pulse, 1 cycle after capture.
- Saturation:
  - offset=0x0100, data_x=0x8000 -> tilt_out=0x8000.
  - offset=0xFF00, data_x=0x7FFF -> tilt_out=0x7FFF.
- Watchdog with TIMEOUT_CYCLES=8:
  - In RUN with dir=01, no samples for 8 cycles -> stale=1, dir=00. The next sample clears stale.
  - In CAL, 8 idle cycles -> IDLE. offset unchanged; start_cal restarts CAL and clears stale.
- Disturbances:
  - Recalibration: start_cal in RUN coincident with a sample -> sample dropped, cal_busy=1.
  - Held-high data_update for 10 cycles -> one sample only.
  - reset_n low after 5 CAL samples -> offset=0, and 16 new samples are required.
